// File: rtl/seq_to_par_if.sv
// Handshake bundle between a serial symbol source and the seq_to_par deserializer.
// The source drives start/seq; the deserializer returns the assembled word and status.
interface seq_to_par_if #(
  parameter int PAR_SZ  = 8,
  parameter int WORD_SZ = 1
);
  logic               start;
  logic [WORD_SZ-1:0] seq;
  logic [PAR_SZ-1:0]  par;
  logic               valid;
  logic               busy;
  logic               err;

  modport master (output start, seq, input par, valid, busy, err);
  modport slave  (input start, seq, output par, valid, busy, err);
endinterface

// File: rtl/seq_to_par.sv
// Serial-to-parallel deserializer: decodes one symbol per clock into a bit, packs PAR_SZ
// bits LSB-first and strobes valid for one cycle per word; flags undecodable symbols.
module seq_to_par #(
  parameter int                 PAR_SZ  = 8,
  parameter int                 WORD_SZ = 1,
  parameter logic [WORD_SZ-1:0] BIT0    = '0,
  parameter logic [WORD_SZ-1:0] BIT1    = WORD_SZ'(1)
) (
  input  logic         clk,
  input  logic         reset,
  seq_to_par_if.slave  bus
);
  localparam int               CNT_W    = $clog2(PAR_SZ) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAR_SZ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [PAR_SZ-1:0]   shift_r;
  logic [PAR_SZ-1:0]   par_r;
  logic                valid_r;
  logic                busy_r;
  logic                err_r;
  logic                valid_next_s;
  logic                busy_next_s;
  logic [1:0]          sym_dec_s;
  logic                bit_s;
  logic                bad_s;

  // Returns {bad, bit}: a symbol matching neither code decodes as 0 and is flagged bad.
  function automatic logic [1:0] decode_sym(input logic [WORD_SZ-1:0] sym);
    logic [1:0] res;
    if (sym == BIT1) begin
      res = 2'b01;
    end else if (sym == BIT0) begin
      res = 2'b00;
    end else begin
      res = 2'b10;
    end
    return res;
  endfunction

  // Symbol decode of the current input.
  always_comb begin
    sym_dec_s = decode_sym(bus.seq);
    bit_s     = sym_dec_s[0];
    bad_s     = sym_dec_s[1];
  end

  // Next-state and next registered strobe values.
  always_comb begin
    state_next_s = state_r;
    busy_next_s  = 1'b0;
    valid_next_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_next_s = ST_RECV;
          busy_next_s  = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (cnt_r == CNT_LAST) begin
          state_next_s = ST_DONE;
        end else begin
          busy_next_s  = 1'b1;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
        valid_next_s = 1'b1;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register and registered strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= busy_next_s;
      valid_r <= valid_next_s;
    end
  end

  // Datapath: bit counter, shift register, output word and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r   <= '0;
      shift_r <= '0;
      par_r   <= '0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            cnt_r   <= '0;
            shift_r <= '0;
            err_r   <= 1'b0;
          end
        end
        ST_RECV: begin
          // Shifting in from the top leaves the first symbol in bit 0 after PAR_SZ samples.
          shift_r <= {bit_s, shift_r[PAR_SZ-1:1]};
          cnt_r   <= cnt_r + CNT_W'(1);
          if (bad_s) begin
            err_r <= 1'b1;
          end
        end
        ST_DONE: begin
          par_r <= shift_r;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  assign bus.par   = par_r;
  assign bus.valid = valid_r;
  assign bus.busy  = busy_r;
  assign bus.err   = err_r;
endmodule

// File: tb/tb_seq_to_par.sv
// Scoreboard bench for seq_to_par: a 1-bit-symbol instance and a 2-bit-symbol instance,
// directed frames push expected {err,par}; negedge monitors pop and compare on valid.
module tb_seq_to_par;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  seq_to_par_if #(.PAR_SZ(8), .WORD_SZ(1)) bus8();
  seq_to_par_if #(.PAR_SZ(8), .WORD_SZ(2)) bus2();

  seq_to_par #(.PAR_SZ(8), .WORD_SZ(1), .BIT0(1'b0), .BIT1(1'b1)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8.slave));
  seq_to_par #(.PAR_SZ(8), .WORD_SZ(2), .BIT0(2'b01), .BIT1(2'b10)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave));

  logic [8:0] q8[$];
  logic [8:0] q2[$];
  logic [8:0] exp8, exp2;
  int         run8 = 0, run2 = 0;
  logic       pv8 = 1'b0, pv2 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the 1-bit-symbol instance.
  always @(negedge clk) begin
    if (!reset) begin
      run8 = 0;
      pv8  = 1'b0;
    end else begin
      if (bus8.busy) run8++;
      if (bus8.valid) begin
        check("valid8_single_cycle", pv8, 0);
        check("valid8_expected", q8.size() != 0, 1);
        if (q8.size() != 0) begin
          exp8 = q8.pop_front();
          check("par8", bus8.par, exp8[7:0]);
          check("err8", bus8.err, exp8[8]);
          check("busy8_len", run8, 8);
        end
        run8 = 0;
      end
      pv8 = bus8.valid;
    end
  end

  // Monitor for the 2-bit-symbol instance.
  always @(negedge clk) begin
    if (!reset) begin
      run2 = 0;
      pv2  = 1'b0;
    end else begin
      if (bus2.busy) run2++;
      if (bus2.valid) begin
        check("valid2_single_cycle", pv2, 0);
        check("valid2_expected", q2.size() != 0, 1);
        if (q2.size() != 0) begin
          exp2 = q2.pop_front();
          check("par2", bus2.par, exp2[7:0]);
          check("err2", bus2.err, exp2[8]);
          check("busy2_len", run2, 8);
        end
        run2 = 0;
      end
      pv2 = bus2.valid;
    end
  end

  // glitch_idx: raise start alongside that symbol; abort_idx: pull reset instead of that symbol.
  task automatic send8(input logic [7:0] word, input logic [7:0] exp_par,
                       input int glitch_idx, input int abort_idx);
    @(negedge clk);
    bus8.start = 1'b1;
    if (abort_idx < 0) q8.push_back({1'b0, exp_par});
    @(negedge clk);
    bus8.start = 1'b0;
    check("busy8_after_start", bus8.busy, 1);
    check("err8_after_start", bus8.err, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_idx) begin
        reset = 1'b0;
        #1;
        check("abort_par", bus8.par, 0);
        check("abort_busy", bus8.busy, 0);
        check("abort_valid", bus8.valid, 0);
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      bus8.seq   = word[i];
      bus8.start = (i == glitch_idx);
      @(negedge clk);
    end
    bus8.start = 1'b0;
  endtask

  task automatic send2(input logic [7:0] word, input int bad_idx,
                       input logic [7:0] exp_par, input logic exp_err);
    @(negedge clk);
    bus2.start = 1'b1;
    q2.push_back({exp_err, exp_par});
    @(negedge clk);
    bus2.start = 1'b0;
    check("busy2_after_start", bus2.busy, 1);
    check("err2_after_start", bus2.err, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == bad_idx) bus2.seq = 2'b11;
      else              bus2.seq = word[i] ? 2'b10 : 2'b01;
      @(negedge clk);
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 20 && (q8.size() != 0 || q2.size() != 0); k++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("drain8", q8.size(), 0);
    check("drain2", q2.size(), 0);
  endtask

  initial begin
    reset      = 1'b0;
    bus8.start = 1'b0;
    bus8.seq   = 1'b0;
    bus2.start = 1'b0;
    bus2.seq   = 2'b01;
    @(negedge clk);
    check("rst_par", bus8.par, 0);
    check("rst_valid", bus8.valid, 0);
    check("rst_busy", bus8.busy, 0);
    check("rst_err", bus8.err, 0);
    check("rst_err2", bus2.err, 0);
    reset = 1'b1;

    send8(8'hA5, 8'hA5, -1, -1);
    wait_drain();

    send8(8'h3C, 8'h3C, -1, -1);
    send8(8'hFF, 8'hFF, -1, -1);
    wait_drain();

    send8(8'h96, 8'h96, 4, -1);
    wait_drain();

    send8(8'h5A, 8'h00, -1, 5);
    repeat (12) @(negedge clk);
    check("post_abort_par", bus8.par, 0);
    check("post_abort_busy", bus8.busy, 0);
    send8(8'hC3, 8'hC3, -1, -1);
    wait_drain();
    check("par8_held", bus8.par, 8'hC3);

    send2(8'hFF, 3, 8'hF7, 1'b1);
    wait_drain();
    check("err2_sticky", bus2.err, 1);
    send2(8'h01, -1, 8'h01, 1'b0);
    wait_drain();
    check("err2_clean", bus2.err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
